// File: rtl/sonar_pkg.sv
// rtl/sonar_pkg.sv - shared state encoding, range sentinel and default timing for the sonar scanner
package sonar_pkg;

  // Sequencer states for one ping cycle per channel
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BURST  = 2'd1,
    ST_LISTEN = 2'd2,
    ST_GUARD  = 2'd3
  } sonar_state_t;

  // Range reported when no echo was measured (no object or watchdog expiry)
  localparam logic [15:0] NO_ECHO_RANGE = 16'hFFFF;

  // Default timing, in clk cycles
  localparam int DEF_NUM_CHANNELS   = 8;
  localparam int DEF_BURST_CYCLES   = 25000;
  localparam int DEF_GUARD_CYCLES   = 200000;
  localparam int DEF_TIMEOUT_CYCLES = 600000;

  // Larger of two integers, used to size the shared counters
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - saturating cycle counter with synchronous load and terminal-count compare
module cycle_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic             done
);

  logic [WIDTH-1:0] count_q;

  // Load restarts at zero; counting stops at all-ones so the count never wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= '0;
    end else if (en && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign done = (count_q == limit);

endmodule

// File: rtl/sonar_scan_controller.sv
// rtl/sonar_scan_controller.sv - sweeps transducer channels with burst, listen and guard phases per ping
module sonar_scan_controller
  import sonar_pkg::*;
#(
  parameter int NUM_CHANNELS   = DEF_NUM_CHANNELS,
  parameter int BURST_CYCLES   = DEF_BURST_CYCLES,
  parameter int GUARD_CYCLES   = DEF_GUARD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                            clk,
  input  logic                            rst_in,
  input  logic                            start_in,
  input  logic                            continuous_in,
  output logic                            tof_trigger_out,
  input  logic                            tof_valid_in,
  input  logic [15:0]                     tof_range_in,
  input  logic                            tof_no_object_in,
  output logic                            tx_burst_out,
  output logic [$clog2(NUM_CHANNELS)-1:0] channel_out,
  output logic                            result_valid_out,
  output logic [$clog2(NUM_CHANNELS)-1:0] result_channel_out,
  output logic [15:0]                     result_range_out,
  output logic                            result_hit_out,
  output logic                            sweep_done_out,
  output logic                            busy_out
);

  localparam int CH_W  = $clog2(NUM_CHANNELS);
  localparam int CNT_W = $clog2(max_int(TIMEOUT_CYCLES, GUARD_CYCLES) + 1);

  localparam logic [CH_W-1:0]  LAST_CH     = CH_W'(NUM_CHANNELS - 1);
  // Phase timers compare against length-1 because the entry cycle is count 0
  localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(BURST_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LIMIT = CNT_W'(GUARD_CYCLES - 1);
  // Watchdog fires when the count reaches the full timeout
  localparam logic [CNT_W-1:0] WD_LIMIT    = CNT_W'(TIMEOUT_CYCLES);

  sonar_state_t     state_q;
  sonar_state_t     state_d;
  logic [CH_W-1:0]  channel_d;
  logic             burst_first_q;

  logic             listening;
  logic             echo_hit;
  logic             echo_miss;
  logic             timeout_miss;
  logic             result_event;

  logic [CNT_W-1:0] phase_limit;
  logic             phase_load;
  logic             phase_en;
  logic             phase_done;
  logic             wd_load;
  logic             wd_en;
  logic             wd_done;

  // ToF inputs only count while a ping is outstanding; valid wins over no-object
  assign listening    = (state_q == ST_BURST) || (state_q == ST_LISTEN);
  assign echo_hit     = listening && tof_valid_in;
  assign echo_miss    = listening && !tof_valid_in && tof_no_object_in;
  assign timeout_miss = listening && !tof_valid_in && !tof_no_object_in && wd_done;
  assign result_event = echo_hit || echo_miss || timeout_miss;

  // One timer covers burst and guard lengths; it restarts on every state change
  assign phase_limit = (state_q == ST_GUARD) ? GUARD_LIMIT : BURST_LIMIT;
  assign phase_load  = (state_d != state_q);
  assign phase_en    = (state_q != ST_IDLE);

  // Watchdog spans burst and listen, restarting only when a new ping begins
  assign wd_load = (state_d == ST_BURST) && (state_q != ST_BURST);
  assign wd_en   = listening;

  cycle_timer #(
    .WIDTH (CNT_W)
  ) u_phase_timer (
    .clk   (clk),
    .rst   (rst_in),
    .load  (phase_load),
    .en    (phase_en),
    .limit (phase_limit),
    .done  (phase_done)
  );

  cycle_timer #(
    .WIDTH (CNT_W)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst_in),
    .load  (wd_load),
    .en    (wd_en),
    .limit (WD_LIMIT),
    .done  (wd_done)
  );

  // State, active channel and ping-start marker registers
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= ST_IDLE;
      channel_out   <= '0;
      burst_first_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      channel_out   <= channel_d;
      burst_first_q <= wd_load;
    end
  end

  // Next-state, channel advance and end-of-sweep pulse
  always_comb begin
    state_d        = state_q;
    channel_d      = channel_out;
    sweep_done_out = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          state_d   = ST_BURST;
          channel_d = '0;
        end
      end
      ST_BURST: begin
        if (result_event) begin
          state_d = ST_GUARD;
        end else if (phase_done) begin
          state_d = ST_LISTEN;
        end
      end
      ST_LISTEN: begin
        if (result_event) begin
          state_d = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (phase_done) begin
          if (channel_out < LAST_CH) begin
            state_d   = ST_BURST;
            channel_d = channel_out + CH_W'(1);
          end else begin
            sweep_done_out = 1'b1;
            if (continuous_in) begin
              state_d   = ST_BURST;
              channel_d = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Result capture: valid pulses for one cycle, payload holds until the next result
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      result_valid_out   <= 1'b0;
      result_channel_out <= '0;
      result_range_out   <= '0;
      result_hit_out     <= 1'b0;
    end else begin
      result_valid_out <= result_event;
      if (result_event) begin
        result_channel_out <= channel_out;
        result_range_out   <= echo_hit ? tof_range_in : NO_ECHO_RANGE;
        result_hit_out     <= echo_hit;
      end
    end
  end

  // Decoded from state so an asynchronous reset drops them at once
  assign tx_burst_out    = (state_q == ST_BURST);
  assign busy_out        = (state_q != ST_IDLE);
  assign tof_trigger_out = burst_first_q;

endmodule

// File: tb/tb_sonar_scan_controller.sv
// tb/tb_sonar_scan_controller.sv - directed self-checking bench for sonar_scan_controller
module tb_sonar_scan_controller;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        start_in = 1'b0;
  logic        continuous_in = 1'b0;
  logic        tof_trigger_out;
  logic        tof_valid_in = 1'b0;
  logic [15:0] tof_range_in = 16'd0;
  logic        tof_no_object_in = 1'b0;
  logic        tx_burst_out;
  logic [1:0]  channel_out;
  logic        result_valid_out;
  logic [1:0]  result_channel_out;
  logic [15:0] result_range_out;
  logic        result_hit_out;
  logic        sweep_done_out;
  logic        busy_out;

  int total = 0;
  int bad = 0;

  sonar_scan_controller #(
    .NUM_CHANNELS   (4),
    .BURST_CYCLES   (10),
    .GUARD_CYCLES   (20),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk                (clk),
    .rst_in             (rst_in),
    .start_in           (start_in),
    .continuous_in      (continuous_in),
    .tof_trigger_out    (tof_trigger_out),
    .tof_valid_in       (tof_valid_in),
    .tof_range_in       (tof_range_in),
    .tof_no_object_in   (tof_no_object_in),
    .tx_burst_out       (tx_burst_out),
    .channel_out        (channel_out),
    .result_valid_out   (result_valid_out),
    .result_channel_out (result_channel_out),
    .result_range_out   (result_range_out),
    .result_hit_out     (result_hit_out),
    .sweep_done_out     (sweep_done_out),
    .busy_out           (busy_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_trig(input int n, input logic [1:0] ch);
    repeat (n - 1) tick();
    chk("trig_early", tof_trigger_out, 0);
    tick();
    chk("trig", tof_trigger_out, 1);
    chk("trig_chan", channel_out, ch);
    chk("trig_tx", tx_burst_out, 1);
  endtask

  // Entered on the trigger cycle T; echo presented at T+50 with range 150
  task automatic sweep_chan(input logic [1:0] ch, input logic last);
    chk("sw_trig", tof_trigger_out, 1);
    chk("sw_chan", channel_out, ch);
    chk("sw_tx_first", tx_burst_out, 1);
    tick();
    chk("sw_trig_one", tof_trigger_out, 0);
    repeat (8) tick();
    chk("sw_tx_last", tx_burst_out, 1);
    tick();
    chk("sw_tx_end", tx_burst_out, 0);
    chk("sw_busy", busy_out, 1);
    repeat (40) tick();
    tof_valid_in = 1'b1;
    tof_range_in = 16'd150;
    tick();
    tof_valid_in = 1'b0;
    chk("sw_rv", result_valid_out, 1);
    chk("sw_range", result_range_out, 150);
    chk("sw_hit", result_hit_out, 1);
    chk("sw_rch", result_channel_out, ch);
    tick();
    chk("sw_rv_one", result_valid_out, 0);
    repeat (18) tick();
    chk("sw_done", sweep_done_out, last);
    tick();
    if (last) begin
      chk("sw_idle", busy_out, 0);
      chk("sw_done_one", sweep_done_out, 0);
    end else begin
      chk("sw_next_trig", tof_trigger_out, 1);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy_out, 0);
    chk("rst_tx", tx_burst_out, 0);
    chk("rst_trig", tof_trigger_out, 0);
    chk("rst_rv", result_valid_out, 0);
    chk("rst_range", result_range_out, 0);
    chk("rst_chan", channel_out, 0);
    rst_in = 1'b0;
    repeat (5) tick();
    chk("idle_busy", busy_out, 0);
    chk("idle_trig", tof_trigger_out, 0);

    // Full single sweep, echo 50 cycles after each trigger
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    for (int i = 0; i < 4; i++) sweep_chan(2'(i), i == 3);

    // Watchdog: no response, result 101 cycles after trigger
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    chk("wd_trig", tof_trigger_out, 1);
    repeat (100) tick();
    chk("wd_rv_early", result_valid_out, 0);
    chk("wd_hold_range", result_range_out, 150);
    chk("wd_hold_rch", result_channel_out, 3);
    chk("wd_hold_hit", result_hit_out, 1);
    tick();
    chk("wd_rv", result_valid_out, 1);
    chk("wd_range", result_range_out, 16'hFFFF);
    chk("wd_hit", result_hit_out, 0);
    chk("wd_rch", result_channel_out, 0);

    // No-object report on channel 1
    expect_trig(20, 2'd1);
    repeat (2) tick();
    tof_no_object_in = 1'b1;
    tick();
    tof_no_object_in = 1'b0;
    chk("no_rv", result_valid_out, 1);
    chk("no_range", result_range_out, 16'hFFFF);
    chk("no_hit", result_hit_out, 0);
    chk("no_rch", result_channel_out, 1);
    chk("no_tx", tx_burst_out, 0);

    // Echo on the fifth burst cycle truncates the burst on channel 2
    expect_trig(20, 2'd2);
    repeat (4) tick();
    chk("tr_tx_before", tx_burst_out, 1);
    tof_valid_in = 1'b1;
    tof_range_in = 16'd37;
    tick();
    tof_valid_in = 1'b0;
    chk("tr_tx", tx_burst_out, 0);
    chk("tr_rv", result_valid_out, 1);
    chk("tr_range", result_range_out, 37);
    chk("tr_hit", result_hit_out, 1);
    chk("tr_rch", result_channel_out, 2);
    chk("tr_busy", busy_out, 1);

    // Start while busy plus simultaneous valid/no-object on channel 3
    expect_trig(20, 2'd3);
    repeat (20) tick();
    start_in = 1'b1;
    tof_valid_in = 1'b1;
    tof_no_object_in = 1'b1;
    tof_range_in = 16'd99;
    tick();
    start_in = 1'b0;
    tof_valid_in = 1'b0;
    tof_no_object_in = 1'b0;
    chk("both_rv", result_valid_out, 1);
    chk("both_range", result_range_out, 99);
    chk("both_hit", result_hit_out, 1);
    chk("both_rch", result_channel_out, 3);
    chk("both_chan", channel_out, 3);
    repeat (19) tick();
    chk("both_done", sweep_done_out, 1);
    tick();
    chk("both_idle", busy_out, 0);
    chk("both_no_trig", tof_trigger_out, 0);

    // Continuous mode wraps from channel 3 back to channel 0
    continuous_in = 1'b1;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tof_valid_in = 1'b1;
      tof_range_in = 16'(10 * i + 5);
      tick();
      tof_valid_in = 1'b0;
      chk("ct_rv", result_valid_out, 1);
      chk("ct_range", result_range_out, 10 * i + 5);
      chk("ct_rch", result_channel_out, i);
      if (i < 3) begin
        expect_trig(20, 2'(i + 1));
      end else begin
        repeat (19) tick();
        chk("ct_done", sweep_done_out, 1);
        chk("ct_done_trig", tof_trigger_out, 0);
        tick();
        chk("ct_wrap_trig", tof_trigger_out, 1);
        chk("ct_wrap_chan", channel_out, 0);
        chk("ct_done_one", sweep_done_out, 0);
      end
    end
    continuous_in = 1'b0;

    // Reset during LISTEN clears outputs immediately; late echo is ignored
    repeat (15) tick();
    chk("rl_busy", busy_out, 1);
    #2;
    rst_in = 1'b1;
    #1;
    chk("rl_busy0", busy_out, 0);
    chk("rl_tx", tx_burst_out, 0);
    chk("rl_rv", result_valid_out, 0);
    chk("rl_range", result_range_out, 0);
    chk("rl_rch", result_channel_out, 0);
    chk("rl_hit", result_hit_out, 0);
    chk("rl_chan", channel_out, 0);
    chk("rl_done", sweep_done_out, 0);
    tick();
    rst_in = 1'b0;
    tof_valid_in = 1'b1;
    tof_range_in = 16'd55;
    repeat (5) tick();
    chk("rl_late_rv", result_valid_out, 0);
    chk("rl_late_busy", busy_out, 0);
    chk("rl_late_trig", tof_trigger_out, 0);
    tof_valid_in = 1'b0;

    // Reset mid-burst drops the drive gate without a clock edge
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    repeat (2) tick();
    chk("rb_tx_on", tx_burst_out, 1);
    #2;
    rst_in = 1'b1;
    #1;
    chk("rb_tx_off", tx_burst_out, 0);
    chk("rb_busy", busy_out, 0);
    tick();
    rst_in = 1'b0;
    repeat (3) tick();
    chk("rb_rv", result_valid_out, 0);
    chk("rb_done", sweep_done_out, 0);
    chk("rb_idle", busy_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
